id_ex_skid_stage: RTL
=====================

// Module: id_ex_skid_stage
// PURPOSE
//  Decode->execute pipeline stage of the mips16 core. Captures the two operands read from the register file
//  plus immediate/control/destination fields, and presents them to the ALU through a valid/ready handshake.
//  A 2-entry skid buffer gives full throughput with a registered in_ready. A writeback bypass keeps the
//  captured and held operands coherent with register-file writes that land in the same or later cycles.
// PARAMETERS
//  DATA_W  16  operand / immediate width
//  ADDR_W   4  register address width (16 registers; r0 reads as zero)
//  CTRL_W   8  opaque decoded control bundle width
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset (asserted when 0)
//  flush        in   1       synchronous squash of all held entries (branch taken / exception)
//  in_valid     in   1       decode has an instruction
//  in_ready     out  1       stage can accept; = !skid_valid (registered state only)
//  in_rs_addr   in   ADDR_W  source-1 register address
//  in_rt_addr   in   ADDR_W  source-2 register address
//  in_rs_data   in   DATA_W  register-file read data 1
//  in_rt_data   in   DATA_W  register-file read data 2
//  in_imm       in   DATA_W  sign-extended immediate
//  in_ctrl      in   CTRL_W  decoded control
//  in_dest      in   ADDR_W  destination register
//  in_wen       in   1       instruction writes in_dest
//  wb_en        in   1       writeback is writing the register file this cycle
//  wb_dest      in   ADDR_W  writeback destination
//  wb_data      in   DATA_W  writeback data
//  out_valid    out  1       execute-side entry valid
//  out_ready    in   1       execute accepts
//  out_rs_data, out_rt_data, out_imm  out  DATA_W  head entry operands / immediate
//  out_ctrl out CTRL_W; out_dest out ADDR_W; out_wen out 1   head entry fields
// BEHAVIOUR
//  - Reset (reset==0, async): main_valid=skid_valid=0, all stored fields 0 -> out_valid=0, all out_* = 0,
//    in_ready=1 once reset releases. Reset mid-transfer drops both entries; no partial output.
//  - Transfer in: in_valid&&in_ready at edge. Transfer out: out_valid&&out_ready at edge. Latency 1 cycle;
//    throughput 1/cycle while out_ready held high.
//  - Storage: main (drives out_*) and skid. States by {main_valid,skid_valid}: EMPTY(00) ONE(10) FULL(11).
//    EMPTY: input -> main (ONE). ONE: out taken & input -> main replaced (ONE); out taken, no input -> EMPTY;
//    not taken & input -> skid (FULL). FULL: in_ready=0; out taken -> skid moves to main (ONE).
//  - out_* are stable while out_valid && !out_ready, except the bypass refresh below.
//  - flush=1: main_valid, skid_valid cleared next edge; in_valid in that cycle ignored; flush wins over
//    any simultaneous transfer in or out. Stored data need not be cleared.
//  - Entries with in_wen=1 and in_dest=0 are passed through unchanged (r0 suppression happens at writeback).
// CONFIGURATION
//  ID_EX_BYPASS_EN defined: operand capture muxes wb_data when wb_en && wb_dest==src_addr && src_addr!=0
//    (rs and rt independently). Every held valid entry also stores its rs/rt addresses and, on any edge with
//    wb_en && wb_dest==stored addr && addr!=0, overwrites that operand with wb_data (refresh while stalled).
//    Skid->main move in the same cycle applies the refresh to the moved data.
//  Not defined: operands captured verbatim from in_rs_data/in_rt_data; no address storage, no refresh.
// TESTING
//  1 Reset: drive reset=0 mid-stream with FULL -> out_valid=0, out_*=0, in_ready=1 after release.
//  2 Streaming: out_ready=1, 4 back-to-back in_valid (rs_data 0x0001..0x0004) -> out 1 cycle later, same
//    order, in_ready never drops.
//  3 Backpressure: out_ready=0, send A=0x1111, B=0x2222 -> FULL, in_ready=0, out_rs_data=0x1111 held;
//    release out_ready -> 0x1111 then 0x2222, in_ready=1 after first accept.
//  4 Flush: FULL, then flush=1 with in_valid=1 (0x3333) -> next cycle out_valid=0, 0x3333 never appears.
//  5 Bypass (EN): in_rs_addr=5, in_rs_data=0x0000, wb_en=1 wb_dest=5 wb_data=0xBEEF -> out_rs_data=0xBEEF;
//    wb_dest=0 same case -> 0x0000; without EN -> 0x0000.
//  6 Stall refresh (EN): entry rt_addr=3 held with out_ready=0, wb writes r3=0x00AA two cycles later ->
//    out_rt_data becomes 0x00AA next cycle, and in the skid entry it appears after the skid->main move.

Source files
------------

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: decode->execute stage with a 2-entry skid buffer and registered in_ready.
// Define ID_EX_BYPASS_EN to add the writeback bypass on capture and the refresh of held operands.
module id_ex_skid_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs_addr,
  input  logic [ADDR_W-1:0] in_rt_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_wen
);
  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] dest;
    logic              wen;
`ifdef ID_EX_BYPASS_EN
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
`endif
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_e, main_held, skid_held;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   take_in, take_out, adv;

  // Applies a same-edge register-file write to an entry's operands; r0 is never bypassed.
  function automatic entry_t refresh(input entry_t e);
    entry_t r;
    r = e;
`ifdef ID_EX_BYPASS_EN
    if (wb_en && wb_dest != '0) begin
      if (wb_dest == e.rs_addr) r.rs = wb_data;
      if (wb_dest == e.rt_addr) r.rt = wb_data;
    end
`endif
    return r;
  endfunction

`ifndef ID_EX_BYPASS_EN
  logic unused;
  assign unused = ^{in_rs_addr, in_rt_addr, wb_en, wb_dest, wb_data};
`endif

  always_comb begin
    in_e = '0;
    in_e.rs = in_rs_data;
    in_e.rt = in_rt_data;
    in_e.imm = in_imm;
    in_e.ctrl = in_ctrl;
    in_e.dest = in_dest;
    in_e.wen = in_wen;
`ifdef ID_EX_BYPASS_EN
    in_e.rs_addr = in_rs_addr;
    in_e.rt_addr = in_rt_addr;
`endif
    in_e = refresh(in_e);
    main_held = refresh(main_q);
    skid_held = refresh(skid_q);
    take_in = in_valid && !skid_valid_q;
    take_out = main_valid_q && out_ready;
    adv = !main_valid_q || take_out;
    main_d = !adv ? main_held : skid_valid_q ? skid_held : take_in ? in_e : main_held;
    skid_d = (!skid_valid_q && take_in && !adv) ? in_e : skid_held;
    main_valid_d = !flush && (adv ? (skid_valid_q || take_in) : 1'b1);
    skid_valid_d = !flush && (skid_valid_q ? !take_out : (take_in && !adv));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_rs_data = main_q.rs;
  assign out_rt_data = main_q.rt;
  assign out_imm = main_q.imm;
  assign out_ctrl = main_q.ctrl;
  assign out_dest = main_q.dest;
  assign out_wen = main_q.wen;
endmodule
